// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings and sizing helpers for the serial adder
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: enough to count 0..WIDTH-1, never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for the serial adder
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Producer/consumer side: supplies operands, takes the result
    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder side
    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, one full-adder bit per clock, LSB first
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_sr_q,      a_sr_d;
    logic [WIDTH-1:0] b_sr_q,      b_sr_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_shift;

    // The only arithmetic resource: one bit of A, one bit of B and the held carry
    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result fills from the top so after WIDTH shifts bit 0 sits at the LSB;
    // written as shift/or so that WIDTH=1 needs no special slicing
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                // in_ready_q gates acceptance so the cycle after reset never loads
                if (in_ready_q && bus.in_valid) begin
                    a_sr_d  = bus.op_a;
                    b_sr_d  = bus.op_b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_shift;
                carry_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    // Publish only on completion so sum/cout hold the previous result meanwhile
                    sum_d   = res_shift;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    // All state, including the registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   acc_cyc;
    int   n_cmp;
    int   n_err;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int t;
        logic [8:0] total;
        t = 0;
        @(negedge clk);
        while (!bus8.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("in_ready_before_send", 32'(bus8.in_ready), 32'd1);
        bus8.op_a     = a;
        bus8.op_b     = b;
        bus8.cin      = c;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc       = cyc;
        bus8.in_valid = 1'b0;
        total = 9'(a) + 9'(b) + 9'(c);
        q8.push_back(total);
    endtask

    task automatic recv8(input int hold, input bit chk_busy);
        int t;
        int busy_n;
        logic [7:0] s0;
        logic       c0;
        logic [8:0] exp;
        t      = 0;
        busy_n = 0;
        @(negedge clk);
        while (!bus8.out_valid && t < 100) begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
            t++;
        end
        check_val("out_valid_seen", 32'(bus8.out_valid), 32'd1);
        check_val("latency", 32'(cyc - acc_cyc), 32'd8);
        if (chk_busy) check_val("busy_cycles", 32'(busy_n), 32'd8);
        s0 = bus8.sum;
        c0 = bus8.cout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_out_valid", 32'(bus8.out_valid), 32'd1);
            check_val("hold_sum", 32'(bus8.sum), 32'(s0));
            check_val("hold_cout", 32'(bus8.cout), 32'(c0));
            check_val("hold_in_ready", 32'(bus8.in_ready), 32'd0);
        end
        if (q8.size() == 0) begin
            check_val("unexpected_result", 32'(bus8.out_valid), 32'd0);
        end else begin
            exp = q8.pop_front();
            check_val("sum", 32'(bus8.sum), 32'(exp[7:0]));
            check_val("cout", 32'(bus8.cout), 32'(exp[8]));
        end
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        check_val("post_hs_out_valid", 32'(bus8.out_valid), 32'd0);
        check_val("post_hs_in_ready", 32'(bus8.in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] w1_tab [8];
        logic [2:0] idx;
        logic [1:0] e1;
        int stale;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 32'(bus8.in_ready), 32'd0);
        check_val("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check_val("rst_busy", 32'(bus8.busy), 32'd0);
        check_val("rst_sum", 32'(bus8.sum), 32'd0);
        check_val("rst_cout", 32'(bus8.cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_release_in_ready", 32'(bus8.in_ready), 32'd1);

        // Basic sums
        send8(8'h00, 8'h00, 1'b0); recv8(0, 1'b1);
        send8(8'hFF, 8'h01, 1'b0); recv8(0, 1'b1);
        send8(8'hA5, 8'h5A, 1'b1); recv8(0, 1'b1);
        send8(8'h3C, 8'h0F, 1'b0); recv8(5, 1'b1);

        // New operands offered during RUN cycle 3 must be ignored
        send8(8'h81, 8'h7E, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus8.op_a = 8'h55; bus8.op_b = 8'h22; bus8.cin = 1'b1; bus8.in_valid = 1'b1;
        check_val("busy_in_ready_a", 32'(bus8.in_ready), 32'd0);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check_val("busy_in_ready_b", 32'(bus8.in_ready), 32'd0);
        recv8(0, 1'b0);

        // Reset during RUN cycle 4 aborts the operation
        send8(8'hC3, 8'h3C, 1'b1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q8.delete();
        check_val("abort_out_valid", 32'(bus8.out_valid), 32'd0);
        check_val("abort_busy", 32'(bus8.busy), 32'd0);
        check_val("abort_sum", 32'(bus8.sum), 32'd0);
        check_val("abort_cout", 32'(bus8.cout), 32'd0);
        check_val("abort_in_ready", 32'(bus8.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_val("abort_in_ready_after", 32'(bus8.in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid) stale++;
        end
        check_val("abort_no_stale", 32'(stale), 32'd0);
        send8(8'h12, 8'h34, 1'b0); recv8(0, 1'b1);

        // WIDTH=1: behaves as a registered full adder
        w1_tab[0] = 2'b00; w1_tab[1] = 2'b01; w1_tab[2] = 2'b01; w1_tab[3] = 2'b10;
        w1_tab[4] = 2'b01; w1_tab[5] = 2'b10; w1_tab[6] = 2'b10; w1_tab[7] = 2'b11;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            @(negedge clk);
            check_val("w1_in_ready", 32'(bus1.in_ready), 32'd1);
            bus1.op_a = idx[2]; bus1.op_b = idx[1]; bus1.cin = idx[0]; bus1.in_valid = 1'b1;
            q1.push_back(w1_tab[i]);
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            @(negedge clk);
            check_val("w1_busy", 32'(bus1.busy), 32'd1);
            @(negedge clk);
            check_val("w1_out_valid", 32'(bus1.out_valid), 32'd1);
            e1 = q1.pop_front();
            check_val("w1_result", 32'({bus1.cout, bus1.sum}), 32'(e1));
            bus1.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus1.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
